// File: rtl/matrix_multiply_unit.sv
// Weight-stationary LENGTH x LENGTH systolic MAC array computing C = W x A.
// Weights shift in from the left and stay put; activations flow down; partial sums flow right.
module matrix_multiply_unit #(
  parameter int WIDTH             = 8,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int LENGTH            = 10
) (
  input  logic                         CLK,
  input  logic                         SYNC_RST,
  input  logic                         EN,
  input  logic                         LOAD,
  input  logic [WIDTH-1:0]             Inputs  [0:LENGTH-1],
  input  logic [WIDTH-1:0]             Weights [0:LENGTH-1],
  output logic [ACCUMULATOR_WIDTH-1:0] Result  [0:LENGTH-1]
);

  localparam int AW = ACCUMULATOR_WIDTH;

  logic [WIDTH-1:0] w    [0:LENGTH-1][0:LENGTH-1];
  logic [WIDTH-1:0] a    [0:LENGTH-1][0:LENGTH-1];
  logic [AW-1:0]    p    [0:LENGTH-1][0:LENGTH-1];
  logic [WIDTH-1:0] w_in [0:LENGTH-1][0:LENGTH-1];
  logic [WIDTH-1:0] a_in [0:LENGTH-1][0:LENGTH-1];
  logic [AW-1:0]    p_in [0:LENGTH-1][0:LENGTH-1];

  // Unsigned product, resized to the accumulator, then a wrapping add.
  function automatic logic [AW-1:0] mac(input logic [AW-1:0]    acc,
                                        input logic [WIDTH-1:0] wt,
                                        input logic [WIDTH-1:0] act);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, wt} * {{WIDTH{1'b0}}, act};
    return acc + AW'(prod);
  endfunction

  always_comb begin
    for (int k = 0; k < LENGTH; k++) begin
      a_in[0][k] = Inputs[k];
    end
    for (int i = 1; i < LENGTH; i++) begin
      for (int k = 0; k < LENGTH; k++) begin
        a_in[i][k] = a[i-1][k];
      end
    end
    for (int i = 0; i < LENGTH; i++) begin
      p_in[i][0] = '0;
      w_in[i][0] = Weights[i];
      for (int k = 1; k < LENGTH; k++) begin
        p_in[i][k] = p[i][k-1];
        w_in[i][k] = w[i][k-1];
      end
    end
  end

  // PE registers: MAC uses the weight held before this edge, even while shifting.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      for (int i = 0; i < LENGTH; i++) begin
        for (int k = 0; k < LENGTH; k++) begin
          w[i][k] <= '0;
          a[i][k] <= '0;
          p[i][k] <= '0;
        end
      end
    end else if (EN) begin
      for (int i = 0; i < LENGTH; i++) begin
        for (int k = 0; k < LENGTH; k++) begin
          if (LOAD) w[i][k] <= w_in[i][k];
          a[i][k] <= a_in[i][k];
          p[i][k] <= mac(p_in[i][k], w[i][k], a_in[i][k]);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      Result[i] = p[i][LENGTH-1];
    end
  end

endmodule

// File: tb/tb_matrix_multiply_unit.sv
// Scoreboard bench for matrix_multiply_unit: a 32-bit and a 16-bit accumulator
// instance share stimulus; expected C entries are queued with their due cycle.
module tb_matrix_multiply_unit;

  localparam int L = 10;

  logic        CLK = 1'b0;
  logic        SYNC_RST, EN, LOAD;
  logic [7:0]  in_d [0:L-1];
  logic [7:0]  wt_d [0:L-1];
  logic [31:0] res32 [0:L-1];
  logic [15:0] res16 [0:L-1];

  matrix_multiply_unit #(.WIDTH(8), .ACCUMULATOR_WIDTH(32), .LENGTH(L)) dut32 (
    .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .LOAD(LOAD),
    .Inputs(in_d), .Weights(wt_d), .Result(res32));

  matrix_multiply_unit #(.WIDTH(8), .ACCUMULATOR_WIDTH(16), .LENGTH(L)) dut16 (
    .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .LOAD(LOAD),
    .Inputs(in_d), .Weights(wt_d), .Result(res16));

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    int          lane;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          c = 0;
  logic        zero_due = 1'b0;
  logic        hold_due = 1'b0;
  logic        expect_zero = 1'b0;
  logic [31:0] prev32 [0:L-1];
  logic [15:0] prev16 [0:L-1];
  int          wm [0:L-1][0:L-1];
  int          am [0:L-1][0:L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic check_now();
    for (int i = 0; i < L; i++) begin
      if (zero_due || expect_zero) begin
        check($sformatf("zero32 c%0d l%0d", c, i), res32[i], 32'd0);
        check($sformatf("zero16 c%0d l%0d", c, i), {16'd0, res16[i]}, 32'd0);
      end
      if (hold_due) begin
        check($sformatf("hold32 c%0d l%0d", c, i), res32[i], prev32[i]);
        check($sformatf("hold16 c%0d l%0d", c, i), {16'd0, res16[i]}, {16'd0, prev16[i]});
      end
    end
    for (int n = sb.size() - 1; n >= 0; n--) begin
      if (sb[n].cyc == c) begin
        check($sformatf("c32 c%0d l%0d", c, sb[n].lane), res32[sb[n].lane], sb[n].val);
        check($sformatf("c16 c%0d l%0d", c, sb[n].lane), {16'd0, res16[sb[n].lane]},
              {16'd0, sb[n].val[15:0]});
        sb.delete(n);
      end
    end
    for (int i = 0; i < L; i++) begin
      prev32[i] = res32[i];
      prev16[i] = res16[i];
    end
  endtask

  // Drives controls for one cycle (data already set), checks mid-cycle, advances past the edge.
  task automatic step(input logic en_v, input logic load_v, input logic rstn_v);
    EN = en_v;
    LOAD = load_v;
    SYNC_RST = rstn_v;
    @(negedge CLK);
    check_now();
    @(posedge CLK);
    #1;
    zero_due = !rstn_v;
    hold_due = rstn_v && !en_v;
    if (!rstn_v) sb.delete();
    if (en_v) c++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < L; i++) in_d[i] = 8'd0;
    for (int s = 0; s < n; s++) step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic load_weights();
    for (int s = 0; s < L; s++) begin
      for (int r = 0; r < L; r++) begin
        wt_d[r] = 8'(wm[r][L-1-s]);
        in_d[r] = 8'd0;
      end
      step(1'b1, 1'b1, 1'b1);
    end
    for (int r = 0; r < L; r++) wt_d[r] = 8'(~r);
  endtask

  // Streams am with the skew; stall_at inserts 3 EN=0 cycles, rst_at pulses reset.
  task automatic stream(input int stall_at, input int rst_at);
    logic [31:0] acc;
    int          t0;
    t0 = c;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < L; j++) begin
        acc = 32'd0;
        for (int k = 0; k < L; k++) acc = acc + 32'(wm[i][k] * am[k][j]);
        sb.push_back('{cyc: t0 + i + j + L, lane: i, val: acc});
      end
    end
    for (int s = 0; s < 2 * L - 1; s++) begin
      for (int k = 0; k < L; k++) begin
        if (s - k >= 0 && s - k < L) in_d[k] = 8'(am[k][s-k]);
        else in_d[k] = 8'd0;
      end
      if (s == stall_at) begin
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1);
      end
      if (s == rst_at) begin
        step(1'b1, 1'b0, 1'b0);
        expect_zero = 1'b1;
      end else begin
        step(1'b1, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic rand_mats(input int maxv);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        wm[i][j] = int'($urandom_range(maxv));
        am[i][j] = int'($urandom_range(maxv));
      end
  endtask

  task automatic fill_mats(input int wv, input int av);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        wm[i][j] = wv;
        am[i][j] = av;
      end
  endtask

  initial begin
    EN = 1'b1;
    LOAD = 1'b1;
    SYNC_RST = 1'b0;
    for (int i = 0; i < L; i++) begin
      in_d[i] = 8'($urandom);
      wt_d[i] = 8'($urandom);
    end
    @(posedge CLK);
    #1;

    // Reset held two cycles with live data and LOAD high.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < L; i++) begin
      in_d[i] = 8'($urandom);
      wt_d[i] = 8'($urandom);
    end
    step(1'b1, 1'b1, 1'b0);
    drain(2);

    // Identity weights.
    rand_mats(10);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) wm[i][j] = (i == j) ? 1 : 0;
    load_weights();
    stream(-1, -1);
    drain(3 * L);

    // Random product, two back-to-back A streams on the same weights.
    rand_mats(10);
    load_weights();
    stream(-1, -1);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) am[i][j] = int'($urandom_range(10));
    stream(-1, -1);
    drain(3 * L);

    // All ones.
    fill_mats(1, 1);
    load_weights();
    stream(-1, -1);
    drain(3 * L);

    // Enable stall mid-stream.
    rand_mats(10);
    load_weights();
    stream(6, -1);
    drain(3 * L);

    // Accumulator wrap on the 16-bit instance.
    fill_mats(255, 255);
    load_weights();
    stream(-1, -1);
    drain(3 * L);

    // Reset mid-stream: everything after it must read zero.
    rand_mats(10);
    load_weights();
    stream(-1, 8);
    drain(3 * L);
    expect_zero = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_multiply_unit.md
Name: matrix_multiply_unit

Overview:
- Weight-stationary LENGTH x LENGTH systolic array of unsigned multiply-accumulate processing elements (PEs). It computes C = W x A for square matrices.
- W is shifted in column-by-column and held stationary. A is streamed in skewed, one row of A per input lane.
- C emerges skewed, one row of C per output lane.
- It is the core compute tile of the accelerator; the upstream sequencer handles skewing and de-skewing.

Parameters:
- WIDTH, 8, bit width of each input and weight element (unsigned).
- ACCUMULATOR_WIDTH, 32, bit width of partial sums and results (unsigned, wraps modulo 2^ACCUMULATOR_WIDTH).
- LENGTH, 10, array dimension (LENGTH x LENGTH PEs, LENGTH lanes).

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- SYNC_RST  in  1  reset; synchronous and active-low.
- EN  in  1  global enable; when low, all state holds.
- LOAD  in  1  weight-shift enable (effective only when EN=1).
- Inputs  in  unpacked array [0:LENGTH-1] of WIDTH  activation lanes; lane k feeds PE column k from the top.
- Weights  in  unpacked array [0:LENGTH-1] of WIDTH  weight lanes; lane r feeds PE row r from the left.
- Result  out  unpacked array [0:LENGTH-1] of ACCUMULATOR_WIDTH  lane i is the partial-sum register of PE[i][LENGTH-1].

Behaviour:
- Each PE[i][k] holds three registers:
  - w: WIDTH bits.
  - a: WIDTH bits, passed down.
  - p: ACCUMULATOR_WIDTH bits, passed right.
- Reset (SYNC_RST=0 at a rising edge) clears every w, a and p to 0, so all Result lanes read 0. Reset has priority over EN and LOAD.
- EN=0: every register holds its value; Result is stable.
- Weight shift (EN=1, LOAD=1), per edge:
  - w[r][0] <= Weights[r].
  - w[r][k] <= w[r][k-1] for k>=1.
  - The last column's value is discarded.
  - After >= LENGTH shifts, presenting column c = LENGTH-1 down to 0 (Weights[r] = W[r][c]) in the last LENGTH LOAD cycles leaves w[r][k] = W[r][k]. Earlier shifted values fall off the right edge.
- EN=1, LOAD=0: weights hold.
- Dataflow (every edge with EN=1, independent of LOAD):
  - a_in[0][k] = Inputs[k]; a_in[i][k] = a[i-1][k]; a[i][k] <= a_in[i][k].
  - p_in[i][0] = 0; p_in[i][k] = p[i][k-1]; p[i][k] <= p_in[i][k] + w[i][k]*a_in[i][k].
- Arithmetic: the WIDTH x WIDTH product is unsigned, 2*WIDTH bits, zero-extended (or truncated) to ACCUMULATOR_WIDTH. The add wraps with no saturation and no overflow flag.
- Result[i] = p[i][LENGTH-1] (registered output, no combinational path from inputs).
- Skew and latency contract:
  - Drive Inputs[k] = A[k][j] during cycle t0+j+k, and 0 otherwise.
  - Then Result[i] = C[i][j] = sum_k W[i][k]*A[k][j] during cycle t0+i+j+LENGTH (after the edge ending cycle t0+i+j+LENGTH-1).
  - Pipeline depth is LENGTH edges for lane 0; lane i is delayed by an additional i cycles.
- Back-to-back operation:
  - A new A stream may start as soon as the previous stream's last input is in. Zeros on idle lanes keep streams independent.
  - Reloading weights while an A stream is in flight corrupts that stream; the sequencer must not do this.
- Reset mid-operation clears all weights and partial sums. Weights must be reloaded before further valid results.

Test Plan:
- Reset: hold SYNC_RST=0 two cycles with random Inputs/Weights, EN=1, LOAD=1 -> every Result lane = 0 on the next cycle and while reset is held.
- Identity weights: load W=I (LENGTH=10), stream a random A in 0..10 with the skew above -> Result[i] = A[i][j] in cycle t0+i+j+10.
- Random product: W and A random in 0..10, LENGTH=10 -> every de-skewed C[i][j] equals the software W x A. Also run all-ones W and A -> every entry = 10.
- Enable stall: deassert EN for 3 cycles mid-stream, freezing Inputs during the stall -> all C values correct and the whole output schedule shifts by exactly 3 cycles.
- Wrap-around: ACCUMULATOR_WIDTH=16, W and A all 255, LENGTH=10 -> every entry = 650250 mod 65536 = 60426.
- Mid-stream reset: pulse SYNC_RST=0 for one cycle during streaming -> Result = 0 next cycle. Continued inputs without a weight reload give all-zero results.
